// File: rtl/hash160_stream_host.sv
// hash160_stream_host: host-side driver for a byte-serial Hash160 core.
// Accepts a 512-bit block, streams START_BYTE plus 64 data bytes on o_text,
// then gathers five 32-bit answer words into a 160-bit digest for upstream.
// Optional abort watchdog on WAIT/COLLECT is enabled with `define HASH160_TIMEOUT_EN.
// The hash core must share rst_n with this block: it captures once per reset.
module hash160_stream_host #(
  parameter logic [7:0]  START_BYTE     = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 4095
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [511:0] i_block,
  input  logic         i_block_valid,
  output logic         o_block_ready,
  output logic [7:0]   o_text,
  input  logic         i_valid,
  input  logic [31:0]  i_answer,
  output logic [159:0] o_digest,
  output logic         o_digest_valid,
  input  logic         i_digest_ready,
  output logic         o_busy,
  output logic         o_timeout
);

  localparam int unsigned BYTE_CNT_W = 6;
  localparam int unsigned WORD_CNT_W = 3;
  localparam logic [BYTE_CNT_W-1:0] LAST_BYTE = BYTE_CNT_W'(63);
  localparam logic [WORD_CNT_W-1:0] LAST_WORD = WORD_CNT_W'(4);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_SEND,
    S_WAIT,
    S_COLLECT,
    S_DONE
  } state_e;

  state_e                  state_q;
  logic [511:0]            shreg_q;
  logic [BYTE_CNT_W-1:0]   byte_cnt_q;
  logic [WORD_CNT_W-1:0]   word_cnt_q;
  logic [7:0]              text_q;
  logic [159:0]            digest_q;
  logic                    digest_valid_q;
  logic                    block_ready_q;
  logic                    busy_q;

`ifdef HASH160_TIMEOUT_EN
  localparam int unsigned TMO_W = 12;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0] tmo_cnt_q;
  logic             timeout_q;
`else
  logic unused_tmo_param;
  assign unused_tmo_param = ^12'(TIMEOUT_CYCLES);
`endif

  // Control FSM with registered outputs; counters and shift register update here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      shreg_q        <= '0;
      byte_cnt_q     <= '0;
      word_cnt_q     <= '0;
      text_q         <= '0;
      digest_q       <= '0;
      digest_valid_q <= 1'b0;
      block_ready_q  <= 1'b0;
      busy_q         <= 1'b0;
`ifdef HASH160_TIMEOUT_EN
      tmo_cnt_q      <= '0;
      timeout_q      <= 1'b0;
`endif
    end else begin
`ifdef HASH160_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          text_q <= '0;
          if (block_ready_q && i_block_valid) begin
            shreg_q       <= i_block;
            digest_q      <= '0;
            byte_cnt_q    <= '0;
            word_cnt_q    <= '0;
            block_ready_q <= 1'b0;
            busy_q        <= 1'b1;
            state_q       <= S_HEADER;
          end else begin
            block_ready_q <= 1'b1;
          end
        end

        S_HEADER: begin
          text_q     <= START_BYTE;
          byte_cnt_q <= '0;
          state_q    <= S_SEND;
        end

        S_SEND: begin
          text_q  <= shreg_q[511:504];
          shreg_q <= {shreg_q[503:0], 8'h00};
          if (byte_cnt_q == LAST_BYTE) begin
            byte_cnt_q <= '0;
            state_q    <= S_WAIT;
`ifdef HASH160_TIMEOUT_EN
            tmo_cnt_q  <= '0;
`endif
          end else begin
            byte_cnt_q <= byte_cnt_q + BYTE_CNT_W'(1);
          end
        end

        S_WAIT, S_COLLECT: begin
          text_q <= '0;
`ifdef HASH160_TIMEOUT_EN
          tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
          if (tmo_cnt_q == TMO_LAST) begin
            timeout_q     <= 1'b1;
            digest_q      <= '0;
            word_cnt_q    <= '0;
            busy_q        <= 1'b0;
            block_ready_q <= 1'b1;
            state_q       <= S_IDLE;
          end else
`endif
          if (i_valid) begin
            digest_q[159 - 32*int'(word_cnt_q) -: 32] <= i_answer;
            word_cnt_q <= word_cnt_q + WORD_CNT_W'(1);
            if (word_cnt_q == LAST_WORD) begin
              digest_valid_q <= 1'b1;
              state_q        <= S_DONE;
            end else begin
              state_q        <= S_COLLECT;
            end
          end
        end

        S_DONE: begin
          text_q <= '0;
          if (i_digest_ready) begin
            digest_valid_q <= 1'b0;
            word_cnt_q     <= '0;
            busy_q         <= 1'b0;
            block_ready_q  <= 1'b1;
            state_q        <= S_IDLE;
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign o_block_ready  = block_ready_q;
  assign o_text         = text_q;
  assign o_digest       = digest_q;
  assign o_digest_valid = digest_valid_q;
  assign o_busy         = busy_q;
`ifdef HASH160_TIMEOUT_EN
  assign o_timeout      = timeout_q;
`else
  assign o_timeout      = 1'b0;
`endif

endmodule
